// File: rtl/i2s_transmitter.sv
// Philips I2S master transmitter: derives BCLK/LRCLK from MCLK and serializes stereo pairs MSB-first.
// Build option I2S_TX_UNDERRUN_HOLD_EN: on underrun, replay the last pair instead of sending silence.
module i2s_transmitter #(
    parameter int BIT_DEPTH  = 24,
    parameter int SLOT_WIDTH = 32,
    parameter int BCLK_DIV   = 4
) (
    input  logic                 MCLK,
    input  logic                 RST,
    input  logic [BIT_DEPTH-1:0] TX_LEFT,
    input  logic [BIT_DEPTH-1:0] TX_RIGHT,
    input  logic                 TX_VALID,
    output logic                 TX_READY,
    output logic                 BCLK,
    output logic                 LRCLK,
    output logic                 SDATA,
    output logic                 UNDERRUN
);

    localparam int BW = $clog2(2 * SLOT_WIDTH);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [BW-1:0]        B_LAST     = BW'(2 * SLOT_WIDTH - 1);
    localparam logic [BW-1:0]        SLOT       = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0]        LR_FIRST   = BW'(SLOT_WIDTH - 1);
    localparam logic [BW-1:0]        LR_LAST    = BW'(2 * SLOT_WIDTH - 2);
    localparam logic [BW-1:0]        DEPTH      = BW'(BIT_DEPTH);
    localparam logic [DW-1:0]        DIV_LAST   = DW'(BCLK_DIV - 1);
    localparam logic [BIT_DEPTH-1:0] MSB_MASK   = ~({BIT_DEPTH{1'b1}} >> 1);

    logic [DW-1:0]        div_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [BIT_DEPTH-1:0] buf_left;
    logic [BIT_DEPTH-1:0] buf_right;
    logic [BIT_DEPTH-1:0] frame_left;
    logic [BIT_DEPTH-1:0] frame_right;

    logic                 div_term;
    logic                 bclk_fall;
    logic                 frame_start;
    logic                 accept;
    logic [BW-1:0]        bit_next;
    logic [BW-1:0]        slot_bit;
    logic                 in_right;
    logic [BIT_DEPTH-1:0] next_left;
    logic [BIT_DEPTH-1:0] next_right;
    logic [BIT_DEPTH-1:0] word;
    logic [BIT_DEPTH-1:0] msb_first;
    logic                 next_bit;

    // Handshake: a pair transfers on any MCLK edge where TX_VALID && TX_READY; TX_READY
    // is high exactly while the holding buffer is empty, independent of TX_VALID.
    assign accept      = TX_VALID && TX_READY;
    assign div_term    = (div_cnt == DIV_LAST);
    assign bclk_fall   = div_term && BCLK;
    assign bit_next    = (bit_cnt == B_LAST) ? '0 : bit_cnt + 1'b1;
    assign frame_start = bclk_fall && (bit_next == '0);

    // Frame contents seen by the serializer this cycle, so the left MSB can leave on the frame-start edge.
    always_comb begin
        next_left  = frame_left;
        next_right = frame_right;
        if (frame_start) begin
            if (!TX_READY) begin
                next_left  = buf_left;
                next_right = buf_right;
            end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                next_left  = frame_left;
                next_right = frame_right;
`else
                next_left  = '0;
                next_right = '0;
`endif
            end
        end
    end

    always_comb begin
        in_right  = (bit_next >= SLOT);
        slot_bit  = in_right ? (bit_next - SLOT) : bit_next;
        word      = in_right ? next_right : next_left;
        msb_first = word << slot_bit;
        next_bit  = (slot_bit < DEPTH) && (|(msb_first & MSB_MASK));
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            div_cnt     <= '0;
            bit_cnt     <= B_LAST;
            BCLK        <= 1'b0;
            LRCLK       <= 1'b0;
            SDATA       <= 1'b0;
            UNDERRUN    <= 1'b0;
            TX_READY    <= 1'b1;
            buf_left    <= '0;
            buf_right   <= '0;
            frame_left  <= '0;
            frame_right <= '0;
        end else begin
            UNDERRUN <= 1'b0;

            if (div_term) begin
                div_cnt <= '0;
                BCLK    <= ~BCLK;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (bclk_fall) begin
                bit_cnt <= bit_next;
                LRCLK   <= (bit_next >= LR_FIRST) && (bit_next <= LR_LAST);
                SDATA   <= next_bit;
            end

            if (frame_start) begin
                frame_left  <= next_left;
                frame_right <= next_right;
                UNDERRUN    <= TX_READY;
            end

            // A full buffer never accepts, so draining and filling cannot collide.
            if (frame_start && !TX_READY) begin
                TX_READY <= 1'b1;
            end else if (accept) begin
                TX_READY  <= 1'b0;
                buf_left  <= TX_LEFT;
                buf_right <= TX_RIGHT;
            end
        end
    end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Self-checking bench for i2s_transmitter (BCLK_DIV=2, SLOT_WIDTH=32, BIT_DEPTH=24).
// Honours I2S_TX_UNDERRUN_HOLD_EN when the design is built with it.
module tb_i2s_transmitter;

    localparam int BIT_DEPTH  = 24;
    localparam int SLOT_WIDTH = 32;
    localparam int BCLK_DIV   = 2;
    localparam int FRAME_BITS = 2 * SLOT_WIDTH;

    logic                 MCLK     = 1'b0;
    logic                 RST      = 1'b1;
    logic [BIT_DEPTH-1:0] TX_LEFT  = '0;
    logic [BIT_DEPTH-1:0] TX_RIGHT = '0;
    logic                 TX_VALID = 1'b0;
    logic                 TX_READY;
    logic                 BCLK;
    logic                 LRCLK;
    logic                 SDATA;
    logic                 UNDERRUN;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Scoreboard: pairs pushed when accepted (with the accepting edge number), popped at frame start.
    logic [2*BIT_DEPTH-1:0] exp_q[$];
    int                     acc_q[$];

    i2s_transmitter #(
        .BIT_DEPTH (BIT_DEPTH),
        .SLOT_WIDTH(SLOT_WIDTH),
        .BCLK_DIV  (BCLK_DIV)
    ) dut (
        .MCLK    (MCLK),
        .RST     (RST),
        .TX_LEFT (TX_LEFT),
        .TX_RIGHT(TX_RIGHT),
        .TX_VALID(TX_VALID),
        .TX_READY(TX_READY),
        .BCLK    (BCLK),
        .LRCLK   (LRCLK),
        .SDATA   (SDATA),
        .UNDERRUN(UNDERRUN)
    );

    // ---------------- clock / reset ----------------
    always #5 MCLK = ~MCLK;
    always @(posedge MCLK) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    task automatic apply_reset();
        TX_VALID = 1'b0;
        RST      = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        RST = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic tick(output logic accepted);
        logic will;
        will = TX_VALID && TX_READY;
        @(posedge MCLK);
        #1;
        if (will) begin
            exp_q.push_back({TX_LEFT, TX_RIGHT});
            acc_q.push_back(cyc);
        end
        accepted = will;
    endtask

    // ---------------- monitor / scoreboard ----------------
    int                     bit_idx   = FRAME_BITS - 1;
    logic                   prev_bclk = 1'b0;
    logic                   rst_prev  = 1'b1;
    logic                   in_frame  = 1'b0;
    logic                   is_start;
    logic                   exp_udr;
    logic                   exp_lr;
    logic [FRAME_BITS-1:0]  rx;
    logic [FRAME_BITS-1:0]  exp_frame;
    logic [2*BIT_DEPTH-1:0] cur_exp;
    logic [2*BIT_DEPTH-1:0] last_frame = '0;

    always @(negedge MCLK) begin
        if (rst_prev) begin
            bit_idx    = FRAME_BITS - 1;
            prev_bclk  = 1'b0;
            in_frame   = 1'b0;
            last_frame = '0;
            exp_q.delete();
            acc_q.delete();
        end else begin
            is_start = 1'b0;
            if (prev_bclk && !BCLK) begin
                bit_idx = (bit_idx + 1) % FRAME_BITS;
                if (bit_idx == 0) begin
                    is_start = 1'b1;
                    exp_udr  = !(exp_q.size() > 0 && acc_q[0] < cyc);
                    n_checks++;
                    if (UNDERRUN !== exp_udr)
                        $display("FAIL frame_underrun: UNDERRUN=%b expected %b at cycle %0d", UNDERRUN, exp_udr, cyc);
                    else
                        n_pass++;
                    if (!exp_udr) begin
                        cur_exp = exp_q.pop_front();
                        void'(acc_q.pop_front());
                    end else begin
`ifdef I2S_TX_UNDERRUN_HOLD_EN
                        cur_exp = last_frame;
`else
                        cur_exp = '0;
`endif
                    end
                    last_frame = cur_exp;
                    in_frame   = 1'b1;
                    rx         = '0;
                end
                exp_lr = (bit_idx >= SLOT_WIDTH - 1) && (bit_idx <= 2 * SLOT_WIDTH - 2);
                n_checks++;
                if (LRCLK !== exp_lr)
                    $display("FAIL lrclk_bit: LRCLK=%b expected %b at slot bit %0d", LRCLK, exp_lr, bit_idx);
                else
                    n_pass++;
                if (in_frame) begin
                    rx = {rx[FRAME_BITS-2:0], SDATA};
                    if (bit_idx == FRAME_BITS - 1) begin
                        exp_frame = {cur_exp[2*BIT_DEPTH-1:BIT_DEPTH], 8'h00, cur_exp[BIT_DEPTH-1:0], 8'h00};
                        n_checks++;
                        if (rx !== exp_frame)
                            $display("FAIL frame_data: got %h expected %h", rx, exp_frame);
                        else
                            n_pass++;
                        in_frame = 1'b0;
                    end
                end
            end
            if (!is_start) begin
                n_checks++;
                if (UNDERRUN !== 1'b0)
                    $display("FAIL underrun_idle: UNDERRUN=%b expected 0 at cycle %0d", UNDERRUN, cyc);
                else
                    n_pass++;
            end
            prev_bclk = BCLK;
        end
        rst_prev = RST;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic acc, pb, plr;
        int   last_bclk_t, bad_bclk, first_lr, last_lr, bad_lr;
        int   first_udr, last_udr, bad_udr, n_udr, sd_ones;
        apply_reset();
        n_checks++; if (BCLK !== 1'b0) $display("FAIL rst_bclk: got %b expected 0", BCLK); else n_pass++;
        n_checks++; if (LRCLK !== 1'b0) $display("FAIL rst_lrclk: got %b expected 0", LRCLK); else n_pass++;
        n_checks++; if (SDATA !== 1'b0) $display("FAIL rst_sdata: got %b expected 0", SDATA); else n_pass++;
        n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL rst_underrun: got %b expected 0", UNDERRUN); else n_pass++;
        n_checks++; if (TX_READY !== 1'b1) $display("FAIL rst_ready: got %b expected 1", TX_READY); else n_pass++;
        pb = BCLK; plr = LRCLK;
        last_bclk_t = 0; bad_bclk = 0; first_lr = -1; last_lr = 0; bad_lr = 0;
        first_udr = -1; last_udr = 0; bad_udr = 0; n_udr = 0; sd_ones = 0;
        for (int n = 1; n <= 600; n++) begin
            tick(acc);
            if (BCLK !== pb) begin
                if (n - last_bclk_t != BCLK_DIV) bad_bclk++;
                last_bclk_t = n;
                pb = BCLK;
            end
            if (LRCLK && !plr) begin
                if (first_lr < 0) first_lr = n;
                else if (n - last_lr != 256) bad_lr++;
                last_lr = n;
            end
            plr = LRCLK;
            if (UNDERRUN) begin
                n_udr++;
                if (first_udr < 0) first_udr = n;
                else if (n - last_udr != 256) bad_udr++;
                last_udr = n;
            end
            if (SDATA !== 1'b0) sd_ones++;
        end
        n_checks++; if (bad_bclk !== 0) $display("FAIL idle_bclk_period: %0d bad half-periods, expected 0", bad_bclk); else n_pass++;
        n_checks++; if (first_lr !== 128) $display("FAIL idle_lrclk_first_rise: cycle %0d expected 128", first_lr); else n_pass++;
        n_checks++; if (bad_lr !== 0) $display("FAIL idle_lrclk_period: %0d bad periods, expected 0", bad_lr); else n_pass++;
        n_checks++; if (first_udr !== 4) $display("FAIL idle_first_underrun: cycle %0d expected 4", first_udr); else n_pass++;
        n_checks++; if (n_udr !== 3) $display("FAIL idle_underrun_count: %0d expected 3", n_udr); else n_pass++;
        n_checks++; if (bad_udr !== 0) $display("FAIL idle_underrun_period: %0d bad periods, expected 0", bad_udr); else n_pass++;
        n_checks++; if (sd_ones !== 0) $display("FAIL idle_sdata: %0d nonzero cycles, expected 0", sd_ones); else n_pass++;
    endtask

    task automatic test_single();
        logic acc;
        apply_reset();
        TX_LEFT = 24'hA5A5A5; TX_RIGHT = 24'h5A5A5A; TX_VALID = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            tick(acc);
            if (acc) TX_VALID = 1'b0;
            if (n == 1) begin
                n_checks++; if (TX_READY !== 1'b0) $display("FAIL single_ready_n1: got %b expected 0", TX_READY); else n_pass++;
            end
            if (n == 3) begin
                n_checks++; if (TX_READY !== 1'b0) $display("FAIL single_ready_n3: got %b expected 0", TX_READY); else n_pass++;
                n_checks++; if (SDATA !== 1'b0) $display("FAIL single_sdata_n3: got %b expected 0", SDATA); else n_pass++;
            end
            if (n == 4) begin
                n_checks++; if (TX_READY !== 1'b1) $display("FAIL single_ready_n4: got %b expected 1", TX_READY); else n_pass++;
                n_checks++; if (SDATA !== 1'b1) $display("FAIL single_msb_n4: got %b expected 1", SDATA); else n_pass++;
                n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL single_underrun_n4: got %b expected 0", UNDERRUN); else n_pass++;
            end
            if (n == 8) begin
                n_checks++; if (SDATA !== 1'b0) $display("FAIL single_bit1: got %b expected 0", SDATA); else n_pass++;
            end
            if (n == 12) begin
                n_checks++; if (SDATA !== 1'b1) $display("FAIL single_bit2: got %b expected 1", SDATA); else n_pass++;
            end
        end
    endtask

    task automatic test_stream();
        logic                 acc;
        logic [BIT_DEPTH-1:0] val;
        int                   accepts, last_acc, bad_gap, udr;
        apply_reset();
        val = 24'h000100;
        TX_LEFT = val; TX_RIGHT = val ^ 24'hFFFFFF; TX_VALID = 1'b1;
        accepts = 0; last_acc = 0; bad_gap = 0; udr = 0;
        for (int n = 1; n <= 1541; n++) begin
            tick(acc);
            if (n <= 1539 && UNDERRUN) udr++;
            if (n == 1540) begin
                n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL stream_end_underrun: got %b expected 1", UNDERRUN); else n_pass++;
            end
            if (acc) begin
                accepts++;
                if (accepts > 2 && n - last_acc != 256) bad_gap++;
                last_acc = n;
                if (accepts == 6) begin
                    TX_VALID = 1'b0;
                end else begin
                    val = val + 1'b1;
                    TX_LEFT = val; TX_RIGHT = val ^ 24'hFFFFFF;
                end
            end
        end
        n_checks++; if (accepts !== 6) $display("FAIL stream_accepts: %0d expected 6", accepts); else n_pass++;
        n_checks++; if (bad_gap !== 0) $display("FAIL stream_one_per_frame: %0d bad gaps, expected 0", bad_gap); else n_pass++;
        n_checks++; if (udr !== 0) $display("FAIL stream_no_underrun: %0d pulses, expected 0", udr); else n_pass++;
    endtask

    task automatic test_starve();
        logic acc;
        logic exp_msb;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        exp_msb = 1'b1;
`else
        exp_msb = 1'b0;
`endif
        apply_reset();
        TX_LEFT = 24'h800001; TX_RIGHT = 24'h7FFFFF; TX_VALID = 1'b1;
        for (int n = 1; n <= 520; n++) begin
            tick(acc);
            if (acc) TX_VALID = 1'b0;
            if (n == 4) begin
                n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL starve_first_frame_underrun: got %b expected 0", UNDERRUN); else n_pass++;
            end
            if (n == 260) begin
                n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL starve_underrun: got %b expected 1", UNDERRUN); else n_pass++;
                n_checks++; if (SDATA !== exp_msb) $display("FAIL starve_replay_msb: got %b expected %b", SDATA, exp_msb); else n_pass++;
            end
            if (n == 261) begin
                n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL starve_pulse_width: got %b expected 0", UNDERRUN); else n_pass++;
            end
        end
    endtask

    task automatic test_simul();
        logic acc;
        apply_reset();
        for (int n = 1; n <= 520; n++) begin
            if (n == 4) begin
                TX_LEFT = 24'hC30FF0; TX_RIGHT = 24'h123456; TX_VALID = 1'b1;
            end
            tick(acc);
            if (acc) TX_VALID = 1'b0;
            if (n == 4) begin
                n_checks++; if (acc !== 1'b1) $display("FAIL simul_accepted: got %b expected 1", acc); else n_pass++;
                n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL simul_underrun: got %b expected 1", UNDERRUN); else n_pass++;
                n_checks++; if (TX_READY !== 1'b0) $display("FAIL simul_ready_n4: got %b expected 0", TX_READY); else n_pass++;
                n_checks++; if (SDATA !== 1'b0) $display("FAIL simul_sdata_n4: got %b expected 0", SDATA); else n_pass++;
            end
            if (n == 260) begin
                n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL simul_next_underrun: got %b expected 0", UNDERRUN); else n_pass++;
                n_checks++; if (TX_READY !== 1'b1) $display("FAIL simul_ready_n260: got %b expected 1", TX_READY); else n_pass++;
                n_checks++; if (SDATA !== 1'b1) $display("FAIL simul_msb_n260: got %b expected 1", SDATA); else n_pass++;
            end
        end
    endtask

    task automatic test_mid_reset();
        logic acc;
        int   n_acc;
        apply_reset();
        n_acc = 0;
        TX_LEFT = 24'h13579B; TX_RIGHT = 24'hFEDCBA; TX_VALID = 1'b1;
        for (int n = 1; n <= 164; n++) begin
            tick(acc);
            if (acc) begin
                n_acc++;
                if (n_acc == 1) begin
                    TX_LEFT = 24'hABCDEF; TX_RIGHT = 24'h654321;
                end else begin
                    TX_VALID = 1'b0;
                end
            end
        end
        n_checks++; if (TX_READY !== 1'b0) $display("FAIL midrst_pending: TX_READY=%b expected 0", TX_READY); else n_pass++;
        RST = 1'b1;
        tick(acc);
        RST = 1'b0;
        n_checks++; if (BCLK !== 1'b0) $display("FAIL midrst_bclk: got %b expected 0", BCLK); else n_pass++;
        n_checks++; if (LRCLK !== 1'b0) $display("FAIL midrst_lrclk: got %b expected 0", LRCLK); else n_pass++;
        n_checks++; if (SDATA !== 1'b0) $display("FAIL midrst_sdata: got %b expected 0", SDATA); else n_pass++;
        n_checks++; if (UNDERRUN !== 1'b0) $display("FAIL midrst_underrun: got %b expected 0", UNDERRUN); else n_pass++;
        n_checks++; if (TX_READY !== 1'b1) $display("FAIL midrst_ready: got %b expected 1", TX_READY); else n_pass++;
        for (int n = 1; n <= 264; n++) begin
            tick(acc);
            if (n == 4) begin
                n_checks++; if (UNDERRUN !== 1'b1) $display("FAIL midrst_discard: UNDERRUN=%b expected 1", UNDERRUN); else n_pass++;
                n_checks++; if (SDATA !== 1'b0) $display("FAIL midrst_sdata_n4: got %b expected 0", SDATA); else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_starve();
        test_simul();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
